// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a two-entry skid buffer, registered in_ready and synchronous flush.
// Optional stall counter (stall_cnt port) is enabled by defining PIPE_SKID_REG_STAT_EN.
//
// state | meaning
// EMPTY | neither main nor skid holds a payload
// ONE   | main holds the head payload
// FULL  | main holds the head, skid holds the next payload
module pipe_skid_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_REG_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("pipe_skid_reg: WIDTH and CNT_WIDTH must be at least 1");
  end

  assign out_data = main_q;

  // in_ready/out_valid are kept as flops that track state, so neither has a combinational input path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            main_q <= in_data;
          end else if (in_valid) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_REG_STAT_EN
  // Counts cycles the head payload waits on downstream; flush leaves the history intact
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed handshake scenarios followed by random traffic.
// Covers the stall counter as well when PIPE_SKID_REG_STAT_EN is defined.
module tb_pipe_skid_reg;

  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_SKID_REG_STAT_EN
  logic [CW-1:0]    stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  bit               model_clean = 1'b1;
  int               model_stall = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL('0),
    .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_SKID_REG_STAT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable from posedge+1 until the next posedge, so the negedge sees what the DUT will sample
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_clean = 1'b1;
      model_stall = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
    end else begin
      check("sb_out_valid", out_valid, exp_q.size() != 0);
      check("sb_in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() != 0)
        check("sb_out_data", out_data, exp_q[0]);
      else if (model_clean)
        check("sb_empty_data", out_data, 0);
`ifdef PIPE_SKID_REG_STAT_EN
      check("sb_stall_cnt", stall_cnt, model_stall);
      if (exp_q.size() != 0 && !out_ready && model_stall < 15)
        model_stall++;
`endif
      if (flush) begin
        exp_q.delete();
        model_clean = 1'b1;
      end else begin
        bit can_in;
        can_in = exp_q.size() < 2;
        if (exp_q.size() != 0 && out_ready)
          void'(exp_q.pop_front());
        if (in_valid && can_in) begin
          exp_q.push_back(in_data);
          model_clean = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset values
    check("t1_out_valid", out_valid, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_out_data", out_data, 0);

    // streaming
    cyc(1, 32'h11, 1, 0);
    check("t2_d11", out_data, 32'h11);
    check("t2_rdy0", in_ready, 1);
    cyc(1, 32'h22, 1, 0);
    check("t2_d22", out_data, 32'h22);
    cyc(1, 32'h33, 1, 0);
    check("t2_d33", out_data, 32'h33);
    check("t2_rdy2", in_ready, 1);
    cyc(0, 0, 1, 0);
    check("t2_drained", out_valid, 0);

    // skid
    cyc(1, 32'hA1, 0, 0);
    cyc(1, 32'hB2, 0, 0);
    check("t3_full_rdy", in_ready, 0);
    check("t3_full_data", out_data, 32'hA1);
    cyc(0, 0, 0, 0);
    check("t3_hold_data", out_data, 32'hA1);
    cyc(0, 0, 1, 0);
    check("t3_second", out_data, 32'hB2);
    check("t3_rdy_back", in_ready, 1);
    cyc(0, 0, 1, 0);
    check("t3_empty", out_valid, 0);

    // flush in FULL with concurrent input
    cyc(1, 32'hD4, 0, 0);
    cyc(1, 32'hE5, 0, 0);
    cyc(1, 32'hC3, 0, 1);
    check("t4_valid", out_valid, 0);
    check("t4_rdy", in_ready, 1);
    check("t4_data", out_data, 0);
    cyc(0, 0, 1, 0);
    check("t4_no_c3", out_valid, 0);

    // simultaneous in/out in ONE
    cyc(1, 32'h44, 0, 0);
    cyc(1, 32'h55, 1, 0);
    check("t5_data", out_data, 32'h55);
    check("t5_valid", out_valid, 1);
    check("t5_rdy", in_ready, 1);
    cyc(0, 0, 1, 0);

    // asynchronous reset while FULL
    cyc(1, 32'h66, 0, 0);
    cyc(1, 32'h77, 0, 0);
    check("t1b_full", in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t1b_valid", out_valid, 0);
    check("t1b_rdy", in_ready, 1);
    check("t1b_data", out_data, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef PIPE_SKID_REG_STAT_EN
    cyc(1, 32'h88, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    check("t6_sat", stall_cnt, 15);
    cyc(0, 0, 0, 1);
    check("t6_flush_keep", stall_cnt, 15);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_clr", stall_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
`endif

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 24) == 0));
    repeat (3) cyc(0, 0, 1, 0);
    check("end_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
